wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning slave-ack watchdog limit in clk_i cycles (0 = watchdog disabled).
REQ-002 SHALL have one clock and synchronous active-high reset; all state changes on posedge clk_i only.
REQ-003 clk_i  in  1  system clock.
REQ-004 rst_i  in  1  synchronous reset, active-high.
REQ-005 m<n>_cyc_i  in  1  master n bus cycle request (n = 0, 1; likewise below).
REQ-006 m<n>_stb_i  in  1  master n strobe.
REQ-007 m<n>_we_i  in  1  master n write enable.
REQ-008 m<n>_adr_i  in  `ADDR_WIDTH  master n address.
REQ-009 m<n>_dat_i  in  `DATA_WIDTH  master n write data.
REQ-010 m<n>_dat_o  out  `DATA_WIDTH  read data to master n.
REQ-011 m<n>_ack_o  out  1  ack to master n.
REQ-012 m<n>_err_o  out  1  watchdog error to master n.
REQ-013 s_cyc_o  out  1  cycle to shared slave.
REQ-014 s_stb_o  out  1  strobe to slave.
REQ-015 s_we_o  out  1  write enable to slave.
REQ-016 s_adr_o  out  `ADDR_WIDTH  address to slave.
REQ-017 s_dat_o  out  `DATA_WIDTH  write data to slave.
REQ-018 s_dat_i  in  `DATA_WIDTH  slave read data.
REQ-019 s_ack_i  in  1  slave ack.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, ERROR, plus registers gnt (1 bit, granted master) and last (1 bit, previous winner).
REQ-021 IDLE: only one master asserts cyc -> gnt <= that master, next state BUSY; none -> stay IDLE.
REQ-022 IDLE, both cyc high: grant master != last (round robin); last <= winner on every grant.
REQ-023 Arbitration latency: cyc sampled in IDLE at edge k; slave signals driven from edge k+1 onward (exactly 1 cycle).
REQ-024 BUSY: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o combinationally mirror granted master; non-granted master's signals ignored.
REQ-025 IDLE and ERROR: s_cyc_o = s_stb_o = 0; s_we_o = 0, s_adr_o/s_dat_o = 0.
REQ-026 m<n>_ack_o = s_ack_i & (state == BUSY) & (gnt == n) & m<n>_stb_i; combinational, never asserted to non-granted master.
REQ-027 m0_dat_o and m1_dat_o SHALL both equal s_dat_i (broadcast; qualified only by ack).
REQ-028 BUSY, granted master's cyc low at an edge -> IDLE; grant held for entire cyc, including multiple stb phases.
REQ-029 Other master's request arriving while BUSY SHALL wait; it is arbitrated in the IDLE cycle after release (min 1 idle cycle between grants).
REQ-030 Watchdog counter wd (width ceil(log2(TIMEOUT_CYCLES+1))) SHALL increment each BUSY cycle with granted stb high and s_ack_i low; cleared on s_ack_i, stb low, or leaving BUSY.
REQ-031 wd reaching TIMEOUT_CYCLES -> ERROR; wd saturates, never wraps.
REQ-032 ERROR: m<gnt>_err_o = 1 (registered-state decode) while granted stb high; when stb low -> BUSY if cyc still high, else IDLE.
REQ-033 ERROR with granted cyc low at same edge as stb low -> IDLE.
REQ-034 s_ack_i in same cycle wd would hit limit: ack wins, no ERROR.
REQ-035 TIMEOUT_CYCLES = 0: ERROR never entered, m<n>_err_o constant 0.

Reset
REQ-036 rst_i high at an edge -> state IDLE, gnt = 0, last = 1 (m0 wins first tie), wd = 0; overrides any in-flight transfer.
REQ-037 During and after reset until a new grant: all s_* outputs 0, all ack/err outputs 0.

Verification
REQ-038 Reset, then m0 only cyc/stb, adr 0x12, we 0; slave acks 2 cycles later -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o for one cycle, m1_ack_o stays 0.
REQ-039 m0 and m1 request same cycle from reset, each holds cyc 3 cycles -> m0 granted first, 1 idle cycle, then m1; next simultaneous tie -> m0 (last = m1).
REQ-040 m1 granted, m0 asserts cyc mid-transfer -> s_adr_o tracks m1 only until m1 drops cyc; m0 granted after one IDLE cycle.
REQ-041 TIMEOUT_CYCLES = 4, m0 strobes, slave never acks -> m0_err_o high after 4 stalled cycles, s_stb_o low; m0 drops stb -> m0_err_o low, next state per cyc.
REQ-042 Slave acks on exactly the 4th stalled cycle -> m0_ack_o asserted, no err.
REQ-043 rst_i asserted while BUSY with m1 -> next cycle s_cyc_o = 0, ack/err 0, subsequent tie grants m0.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Two-master to one-slave Wishbone arbiter. Round-robin grant on
//            ties, grant held for the whole bus cycle, and a slave-ack
//            watchdog that signals an error to the granted master.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic [`ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [`DATA_WIDTH-1:0] m0_dat_i,
    output logic [`DATA_WIDTH-1:0] m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic [`ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [`DATA_WIDTH-1:0] m1_dat_i,
    output logic [`DATA_WIDTH-1:0] m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [`ADDR_WIDTH-1:0] s_adr_o,
    output logic [`DATA_WIDTH-1:0] s_dat_o,
    input  logic [`DATA_WIDTH-1:0] s_dat_i,
    input  logic                   s_ack_i
);

    // Watchdog counter is at least one bit wide so a disabled watchdog
    // still elaborates cleanly.
    localparam int c_WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_ONE   = c_WD_W'(1);
    localparam bit                c_WD_EN    = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_gnt;
    logic                w_next_gnt;
    logic                r_last;
    logic                w_next_last;
    logic [c_WD_W-1:0]   r_wd;
    logic [c_WD_W-1:0]   w_next_wd;
    logic                w_win;

    // Signals of whichever master currently owns the grant.
    logic                   w_g_cyc;
    logic                   w_g_stb;
    logic                   w_g_we;
    logic [`ADDR_WIDTH-1:0] w_g_adr;
    logic [`DATA_WIDTH-1:0] w_g_dat;

    // Select the granted master's request signals.
    always_comb begin
        w_g_cyc = r_gnt ? m1_cyc_i : m0_cyc_i;
        w_g_stb = r_gnt ? m1_stb_i : m0_stb_i;
        w_g_we  = r_gnt ? m1_we_i  : m0_we_i;
        w_g_adr = r_gnt ? m1_adr_i : m0_adr_i;
        w_g_dat = r_gnt ? m1_dat_i : m0_dat_i;
    end

    // State, grant, round-robin history and watchdog registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_wd    <= '0;
        end else begin
            r_state <= w_next_state;
            r_gnt   <= w_next_gnt;
            r_last  <= w_next_last;
            r_wd    <= w_next_wd;
        end
    end

    // Next-state logic: arbitration in IDLE, cycle tracking and watchdog in
    // BUSY, recovery once the errored master withdraws its strobe.
    always_comb begin
        w_next_state = r_state;
        w_next_gnt   = r_gnt;
        w_next_last  = r_last;
        w_next_wd    = r_wd;
        w_win        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_wd = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    w_win = ~r_last;
                end else begin
                    w_win = m1_cyc_i;
                end
                if (m0_cyc_i || m1_cyc_i) begin
                    w_next_state = ST_BUSY;
                    w_next_gnt   = w_win;
                    w_next_last  = w_win;
                end
            end

            ST_BUSY: begin
                if (!w_g_cyc) begin
                    w_next_state = ST_IDLE;
                    w_next_wd    = '0;
                end else if (w_g_stb && !s_ack_i) begin
                    // A stalled cycle; the one that would bring the count to
                    // the limit raises the error instead of counting on.
                    if (c_WD_EN && (r_wd == (c_WD_LIMIT - c_WD_ONE))) begin
                        w_next_state = ST_ERROR;
                        w_next_wd    = c_WD_LIMIT;
                    end else if (c_WD_EN && (r_wd != c_WD_LIMIT)) begin
                        w_next_wd = r_wd + c_WD_ONE;
                    end
                end else begin
                    w_next_wd = '0;
                end
            end

            ST_ERROR: begin
                if (!w_g_cyc) begin
                    w_next_state = ST_IDLE;
                    w_next_wd    = '0;
                end else if (!w_g_stb) begin
                    w_next_state = ST_BUSY;
                    w_next_wd    = '0;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
                w_next_wd    = '0;
            end
        endcase
    end

    // Slave-side outputs mirror the granted master only while BUSY.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (r_state == ST_BUSY) begin
            s_cyc_o = w_g_cyc;
            s_stb_o = w_g_stb;
            s_we_o  = w_g_we;
            s_adr_o = w_g_adr;
            s_dat_o = w_g_dat;
        end
    end

    // Read data is broadcast; the per-master ack qualifies it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = s_ack_i && (r_state == ST_BUSY) && !r_gnt && m0_stb_i;
    assign m1_ack_o = s_ack_i && (r_state == ST_BUSY) &&  r_gnt && m1_stb_i;

    assign m0_err_o = c_WD_EN && (r_state == ST_ERROR) && !r_gnt && m0_stb_i;
    assign m1_err_o = c_WD_EN && (r_state == ST_ERROR) &&  r_gnt && m1_stb_i;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench for wb_arbiter: directed scenarios followed
//            by randomized traffic, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_wb_arbiter;

    localparam int c_TO = 4;
    localparam int c_AW = `ADDR_WIDTH;
    localparam int c_DW = `DATA_WIDTH;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            cyc [2];
    logic            stb [2];
    logic            we  [2];
    logic [c_AW-1:0] adr [2];
    logic [c_DW-1:0] dat [2];
    logic            s_ack;
    logic [c_DW-1:0] s_rdat;

    logic [c_DW-1:0] m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [c_AW-1:0] s_adr_o;
    logic [c_DW-1:0] s_dat_o;

    logic [c_DW-1:0] nw_m0_dat_o, nw_m1_dat_o;
    logic            nw_m0_ack_o, nw_m1_ack_o, nw_m0_err_o, nw_m1_err_o;
    logic            nw_s_cyc_o, nw_s_stb_o, nw_s_we_o;
    logic [c_AW-1:0] nw_s_adr_o;
    logic [c_DW-1:0] nw_s_dat_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: owner of the bus (-1 = none), error flag, last
    // winner and the number of consecutive stalled strobe cycles.
    int m_owner = -1;
    bit m_err   = 1'b0;
    int m_last  = 1;
    int m_stall = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_rdat), .s_ack_i(s_ack)
    );

    wb_arbiter #(.TIMEOUT_CYCLES(0)) dut_nowd (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat_o(nw_m0_dat_o),
        .m0_ack_o(nw_m0_ack_o), .m0_err_o(nw_m0_err_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat_o(nw_m1_dat_o),
        .m1_ack_o(nw_m1_ack_o), .m1_err_o(nw_m1_err_o),
        .s_cyc_o(nw_s_cyc_o), .s_stb_o(nw_s_stb_o), .s_we_o(nw_s_we_o),
        .s_adr_o(nw_s_adr_o), .s_dat_o(nw_s_dat_o),
        .s_dat_i(s_rdat), .s_ack_i(s_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_step();
        int w;
        if (rst_i) begin
            m_owner = -1; m_err = 1'b0; m_last = 1; m_stall = 0;
        end else if (m_owner < 0) begin
            if (cyc[0] && cyc[1]) w = 1 - m_last;
            else if (cyc[0])      w = 0;
            else if (cyc[1])      w = 1;
            else                  w = -1;
            if (w >= 0) begin
                m_owner = w; m_last = w; m_stall = 0;
            end
        end else if (m_err) begin
            if (!cyc[m_owner]) begin
                m_owner = -1; m_err = 1'b0; m_stall = 0;
            end else if (!stb[m_owner]) begin
                m_err = 1'b0; m_stall = 0;
            end
        end else begin
            if (!cyc[m_owner]) begin
                m_owner = -1; m_stall = 0;
            end else if (stb[m_owner] && !s_ack) begin
                m_stall++;
                if (m_stall >= c_TO) m_err = 1'b1;
            end else begin
                m_stall = 0;
            end
        end
    endtask

    // Compare every DUT output against the model's view of this cycle.
    task automatic compare_all();
        bit busy;
        int o;
        busy = (m_owner >= 0) && !m_err;
        o    = (m_owner < 0) ? 0 : m_owner;
        check("s_cyc", 64'(s_cyc_o), 64'(busy && cyc[o]));
        check("s_stb", 64'(s_stb_o), 64'(busy && stb[o]));
        check("s_we",  64'(s_we_o),  64'(busy && we[o]));
        check("s_adr", 64'(s_adr_o), busy ? 64'(adr[o]) : 64'd0);
        check("s_dat", 64'(s_dat_o), busy ? 64'(dat[o]) : 64'd0);
        check("m0_ack", 64'(m0_ack_o), 64'(s_ack && busy && m_owner == 0 && stb[0]));
        check("m1_ack", 64'(m1_ack_o), 64'(s_ack && busy && m_owner == 1 && stb[1]));
        check("m0_err", 64'(m0_err_o), 64'(m_err && m_owner == 0 && stb[0]));
        check("m1_err", 64'(m1_err_o), 64'(m_err && m_owner == 1 && stb[1]));
        check("m0_dat", 64'(m0_dat_o), 64'(s_rdat));
        check("m1_dat", 64'(m1_dat_o), 64'(s_rdat));
        check("nowd_m0_err", 64'(nw_m0_err_o), 64'd0);
        check("nowd_m1_err", 64'(nw_m1_err_o), 64'd0);
    endtask

    // One clock cycle: update model at the edge, drive new inputs, compare.
    task automatic step(input bit r, input bit c0, input bit s0,
                        input bit c1, input bit s1, input bit ack);
        @(posedge clk_i);
        #1;
        model_step();
        rst_i  = r;
        cyc[0] = c0; stb[0] = s0;
        cyc[1] = c1; stb[1] = s1;
        for (int i = 0; i < 2; i++) begin
            we[i]  = 1'($urandom);
            adr[i] = c_AW'($urandom);
            dat[i] = c_DW'($urandom);
        end
        s_ack  = ack;
        s_rdat = c_DW'($urandom);
        #1;
        compare_all();
    endtask

    initial begin
        bit c0, c1, s0, s1, a, r;
        int ack_pct;

        rst_i = 1'b1; s_ack = 1'b0; s_rdat = '0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; dat[i] = '0;
        end

        // Reset with a request pending: everything must stay quiet.
        step(1, 1, 1, 1, 1, 1);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_s_cyc", 64'(s_cyc_o), 64'd0);

        // Single master read, ack after two wait cycles.
        step(0, 1, 1, 0, 0, 0);
        check("lat_k", 64'(s_cyc_o), 64'd0);
        step(0, 1, 1, 0, 0, 0);
        check("lat_k1", 64'(s_cyc_o), 64'd1);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        check("single_ack_m0", 64'(m0_ack_o), 64'd1);
        check("single_ack_m1", 64'(m1_ack_o), 64'd0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Tie from reset: m0, one idle cycle, m1, then next tie to m0.
        step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 1, 1, 0);
        repeat (5) step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1, 0);
        check("tie2_m0", 64'(s_adr_o), 64'(adr[0]));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // m1 owns the bus; m0 request waits for release.
        step(0, 0, 0, 1, 1, 0);
        repeat (3) step(0, 1, 1, 1, 1, 0);
        check("hold_m1", 64'(s_adr_o), 64'(adr[1]));
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        check("after_m1_m0", 64'(s_adr_o), 64'(adr[0]));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Watchdog: four stalled cycles then error until stb drops.
        step(0, 1, 1, 0, 0, 0);
        repeat (4) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        check("wd_err", 64'(m0_err_o), 64'd1);
        check("wd_stb", 64'(s_stb_o), 64'd0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("wd_err_drop", 64'(m0_err_o), 64'd0);
        step(0, 1, 0, 0, 0, 0);
        check("wd_back_busy", 64'(s_cyc_o), 64'd1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Ack on the fourth stalled cycle wins over the watchdog.
        step(0, 1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        check("wd_edge_ack", 64'(m0_ack_o), 64'd1);
        step(0, 1, 1, 0, 0, 0);
        check("wd_edge_noerr", 64'(m0_err_o), 64'd0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset in the middle of an m1 transfer.
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1, 1);
        check("rst_busy_cyc", 64'(s_cyc_o), 64'd0);
        check("rst_busy_ack", 64'(m1_ack_o), 64'd0);
        step(0, 1, 1, 1, 1, 0);
        check("rst_tie_m0", 64'(s_adr_o), 64'(adr[0]));
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic with varying slave responsiveness.
        c0 = 1'b0; c1 = 1'b0; ack_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 3;
                    1:       ack_pct = 40;
                    default: ack_pct = 90;
                endcase
            end
            if ($urandom_range(0, 5) == 0) c0 = ~c0;
            if ($urandom_range(0, 5) == 0) c1 = ~c1;
            s0 = c0 && ($urandom_range(0, 3) != 0);
            s1 = c1 && ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 99) < ack_pct);
            r  = ($urandom_range(0, 299) == 0);
            step(r, c0, s0, c1, s1, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
